// File: rtl/oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter
//
// Purpose:
//   Sprite-attribute (OAM) DMA engine sharing one memory bus with a CPU.
//   A CPU write to the DMA register latches a source page and starts a copy
//   of DMA_LEN bytes from {src,00..} to {OAM_HI,00..}, one byte every two
//   cycles (READ then WRITE). While the copy runs the engine owns the bus:
//   the CPU only reaches the internal high RAM (HRAM) and the DMA register.
//   Outside a copy, CPU accesses pass straight through to the memory bus.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous reset, active low
//   cpu_addr    CPU bus address
//   cpu_wdata   CPU write data
//   cpu_write   CPU write strobe (one access per cycle)
//   cpu_rdata   CPU read data (combinational)
//   mem_addr    shared memory bus address
//   mem_wdata   shared memory bus write data
//   mem_write   shared memory bus write strobe
//   mem_rdata   shared memory bus read data (combinational)
//   dma_active  high while the DMA engine owns the bus
// -----------------------------------------------------------------------------
module oam_dma_arbiter #(
    parameter int          DMA_LEN = 160,
    parameter logic [15:0] DMA_REG = 16'hFF46,
    parameter logic [7:0]  OAM_HI  = 8'hFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    // Index width covers DMA_LEN-1; a one-byte transfer still needs one bit.
    localparam int IDX_W = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       src_r;
    logic [7:0]       data_r;
    logic [7:0]       hram_r [0:126];

    logic             is_dma_reg_s;
    logic             is_hram_s;
    logic             dma_start_s;
    logic [6:0]       hram_idx_s;
    logic [7:0]       hram_rd_s;
    logic [7:0]       src_eff_s;
    logic [7:0]       idx_byte_s;

    // CPU address decode and derived DMA address bytes.
    always_comb begin
        is_dma_reg_s = (cpu_addr == DMA_REG);
        // FF80..FFFE; FFFF is not part of HRAM.
        is_hram_s    = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
        dma_start_s  = rst && cpu_write && is_dma_reg_s;
        if (is_hram_s) begin
            hram_idx_s = cpu_addr[6:0];
        end else begin
            hram_idx_s = 7'd0;
        end
        hram_rd_s    = hram_r[hram_idx_s];
        // Pages E0..FF are echoes of C0..DF; only the read address is remapped.
        if (src_r >= 8'hE0) begin
            src_eff_s = src_r - 8'h20;
        end else begin
            src_eff_s = src_r;
        end
        idx_byte_s   = 8'(idx_r);
    end

    // DMA sequencer: a DMA register write restarts from any state and wins
    // over the normal WRITE->IDLE/READ step, so a final WRITE still drives
    // the bus in that cycle (outputs decode the current state).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            src_r   <= 8'h00;
            data_r  <= 8'h00;
        end else if (dma_start_s) begin
            src_r   <= cpu_wdata;
            idx_r   <= '0;
            state_r <= ST_START;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_START: begin
                    state_r <= ST_READ;
                end
                ST_READ: begin
                    data_r  <= mem_rdata;
                    state_r <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                    end else begin
                        idx_r   <= idx_r + 1'b1;
                        state_r <= ST_READ;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // HRAM write port; contents survive reset, only writes out of reset land.
    always_ff @(posedge clk) begin
        if (rst && cpu_write && is_hram_s) begin
            hram_r[hram_idx_s] <= cpu_wdata;
        end
    end

    // Bus mux and CPU read data; everything is parked while reset is held.
    always_comb begin
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        mem_write  = 1'b0;
        dma_active = 1'b0;
        cpu_rdata  = 8'hFF;
        if (!rst) begin
            dma_active = 1'b0;
        end else begin
            dma_active = (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    // HRAM and the DMA register are local; never forwarded.
                    mem_write = cpu_write && !is_hram_s && !is_dma_reg_s;
                end
                ST_START: begin
                    mem_addr  = 16'h0000;
                    mem_wdata = data_r;
                    mem_write = 1'b0;
                end
                ST_READ: begin
                    mem_addr  = {src_eff_s, idx_byte_s};
                    mem_wdata = data_r;
                    mem_write = 1'b0;
                end
                ST_WRITE: begin
                    mem_addr  = {OAM_HI, idx_byte_s};
                    mem_wdata = data_r;
                    mem_write = 1'b1;
                end
                default: begin
                    mem_addr  = 16'h0000;
                    mem_wdata = 8'h00;
                    mem_write = 1'b0;
                end
            endcase

            if (is_dma_reg_s) begin
                cpu_rdata = src_r;
            end else if (is_hram_s) begin
                cpu_rdata = hram_rd_s;
            end else if (state_r == ST_IDLE) begin
                cpu_rdata = mem_rdata;
            end else begin
                cpu_rdata = 8'hFF;
            end
        end
    end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 The block SHALL take parameter DMA_LEN, default 160, as the number of bytes copied per transfer.
REQ-002 The block SHALL take parameter DMA_REG, default 16'hFF46, as the DMA start/source register address.
REQ-003 The block SHALL take parameter OAM_HI, default 8'hFE, as the destination page high byte.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cpu_addr  input  16  CPU bus address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_write  input  1  CPU write strobe; one access per cycle.
REQ-009 cpu_rdata  output  8  CPU read data, combinational.
REQ-010 mem_addr  output  16  shared memory bus address.
REQ-011 mem_wdata  output  8  shared memory bus write data.
REQ-012 mem_write  output  1  shared memory bus write strobe.
REQ-013 mem_rdata  input  8  shared memory bus read data, combinational.
REQ-014 dma_active  output  1  high while DMA owns the bus.

Function
REQ-015 States SHALL be IDLE, START, READ, WRITE; dma_active SHALL be high in every state except IDLE.
REQ-016 A CPU write to DMA_REG SHALL latch cpu_wdata into src and move to START from any state, clearing index idx to 0 (write during DMA restarts it).
REQ-017 src values 8'hE0-8'hFF SHALL be used as src-8'h20 for read addresses; the register readback SHALL return the unmodified written value.
REQ-018 START SHALL last exactly one cycle and then go to READ.
REQ-019 In READ: mem_addr={src_eff,idx}, mem_write=0; mem_rdata latched into data register at cycle end; next state WRITE.
REQ-020 In WRITE: mem_addr={OAM_HI,idx}, mem_wdata=data register, mem_write=1; if idx==DMA_LEN-1 next state IDLE, else idx+1 and next state READ.
REQ-021 One transfer SHALL take exactly 1+2*DMA_LEN cycles from START entry to IDLE (321 at default).
REQ-022 The block SHALL contain a 127-byte HRAM at 16'hFF80-16'hFFFE, written on the edge with cpu_write, read combinationally, served in all states, never forwarded to mem bus.
REQ-023 Reads of DMA_REG SHALL return src; writes to DMA_REG SHALL not be forwarded (mem_write=0 that cycle when CPU owns bus).
REQ-024 In IDLE, other CPU accesses SHALL pass through: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_write=cpu_write, cpu_rdata=mem_rdata.
REQ-025 While dma_active, CPU reads outside HRAM and DMA_REG SHALL return 8'hFF and CPU writes there SHALL be dropped.
REQ-026 A CPU DMA_REG write in the same cycle as the final WRITE SHALL win: the final WRITE still occurs, next state START with new src.
REQ-027 idx width SHALL cover DMA_LEN-1; idx SHALL never wrap past DMA_LEN-1.

Reset
REQ-028 When rst=0 at a rising edge: state IDLE, idx 0, src 8'h00, data register 8'h00; HRAM contents unchanged.
REQ-029 While rst=0: mem_addr=16'h0000, mem_write=0, dma_active=0, cpu_rdata=8'hFF.
REQ-030 Reset mid-transfer SHALL abort immediately with no further DMA writes after release.

Verification
REQ-031 CPU writes 8'hC1 to FF46 at cycle T -> START at T+1, READ C100 at T+2, WRITE FE00 at T+3, last WRITE FE9F at T+321, dma_active low at T+322.
REQ-032 Memory C100+i = i^8'h5A, full DMA -> FE00+i holds i^8'h5A for i=0..159; exactly 160 mem_write pulses.
REQ-033 During DMA CPU reads 8000 -> 8'hFF; CPU writes 8'h77 to FF90 then reads FF90 -> 8'h77; writes to C000 -> no mem_write from CPU.
REQ-034 Source 8'hF2 -> reads from D200-D29F; FF46 readback = 8'hF2.
REQ-035 FF46 rewritten with 8'hD0 at idx 50 -> restart from D000/FE00, total 321 cycles from rewrite.
REQ-036 rst low at idx 80 for 1 cycle -> dma_active 0, mem_write 0, no FE write after release.
